// File: rtl/clock_gen_pkg.sv
// Shared definitions for the clock-enable generator.
//   cg_state_e   : top-level FSM states
//   NUM_CH_MAX   : largest supported channel count (cfg_ch is 3 bits wide)
//   CFG_CH_W     : width of the channel-select field
//   default_inc(): reset increment, 2^w/9 truncated, for an accumulator of w bits
package clock_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    ALIGN     = 2'd1,
    RUN       = 2'd2
  } cg_state_e;

  localparam int unsigned NUM_CH_MAX  = 8;
  localparam int unsigned CFG_CH_W    = 3;
  localparam logic [31:0] DEF_INC_32  = 32'h1C71_C71C;

  function automatic logic [31:0] default_inc(input int unsigned w);
    logic [32:0] full;
    full = 33'd1 << w;
    return 32'(full / 33'd9);
  endfunction

endpackage

// File: rtl/clock_enable_nco.sv
// One clock-enable channel: phase accumulator with carry-out pulse.
//   clk, rst      : system clock, synchronous active-high reset
//   cfg_we_i      : write inc/phase registers for this channel
//   cfg_inc_i     : new increment
//   cfg_phase_i   : new start phase (used at the next load)
//   load_i        : align cycle, acc <= phase
//   step_i        : run cycle, acc <= acc + inc, ce <= carry
//   ce_o          : registered carry, one cycle after the add
module clock_enable_nco
  import clock_gen_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we_i,
  input  logic [ACC_WIDTH-1:0] cfg_inc_i,
  input  logic [ACC_WIDTH-1:0] cfg_phase_i,
  input  logic                 load_i,
  input  logic                 step_i,
  output logic                 ce_o
);

  logic [ACC_WIDTH-1:0] inc_q, phase_q, acc_q, acc_d;
  logic                 ce_q, ce_d;
  logic [ACC_WIDTH:0]   sum;

  // One extra bit holds the carry; wrap is plain modulo 2^ACC_WIDTH.
  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  always_comb begin
    acc_d = acc_q;
    ce_d  = 1'b0;
    if (load_i) begin
      acc_d = phase_q;
    end else if (step_i) begin
      acc_d = sum[ACC_WIDTH-1:0];
      ce_d  = sum[ACC_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q   <= ACC_WIDTH'(default_inc(ACC_WIDTH));
      phase_q <= '0;
      acc_q   <= '0;
      ce_q    <= 1'b0;
    end else begin
      // inc takes effect on the next add; phase only matters at the next load.
      if (cfg_we_i) begin
        inc_q   <= cfg_inc_i;
        phase_q <= cfg_phase_i;
      end
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator gated by PLL lock.
//   clk, rst     : system clock (PLL output), synchronous active-high reset
//   pll_locked   : raw lock flag, asynchronous, synchronised here
//   cfg_we/ch    : write strobe and channel index (index >= NUM_CH ignored)
//   cfg_inc      : channel increment, f_ce = f_clk*inc/2^ACC_WIDTH
//   cfg_phase    : channel start phase, applied at the next ALIGN
//   sync_req     : in RUN, realign all channels to their phases
//   ce           : one-cycle enable pulses, one bit per channel
//   ready        : high exactly while in RUN
//   unlock_seen  : sticky, lock lost since reset
module clock_enable_gen
  import clock_gen_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int ACC_WIDTH = 32,
  parameter int LOCK_WAIT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 cfg_we,
  input  logic [CFG_CH_W-1:0]  cfg_ch,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic [ACC_WIDTH-1:0] cfg_phase,
  input  logic                 sync_req,
  output logic [NUM_CH-1:0]    ce,
  output logic                 ready,
  output logic                 unlock_seen
);

  localparam int              CNT_W    = $clog2(LOCK_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  logic             lock_meta_q, lock_q;
  cg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unlock_q, unlock_d;
  logic             load, step;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    unlock_d = unlock_q;
    if (!lock_q) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      // Only a loss after lock was seen counts; the post-reset low period
      // (counter still at zero in WAIT_LOCK) is not an unlock.
      if (state_q != WAIT_LOCK || cnt_q != '0) unlock_d = 1'b1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ALIGN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ALIGN:   state_d = RUN;
        RUN:     if (sync_req) state_d = ALIGN;
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_q      <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      unlock_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_q      <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      unlock_q    <= unlock_d;
    end
  end

  // Accumulators only advance when RUN continues, so any exit from RUN
  // (sync or unlock) leaves a zero ce in the following cycle.
  assign load = (state_q == ALIGN);
  assign step = (state_q == RUN) && (state_d == RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_enable_nco #(.ACC_WIDTH(ACC_WIDTH)) u_nco (
      .clk         (clk),
      .rst         (rst),
      .cfg_we_i    (cfg_we && (cfg_ch == CFG_CH_W'(i))),
      .cfg_inc_i   (cfg_inc),
      .cfg_phase_i (cfg_phase),
      .load_i      (load),
      .step_i      (step),
      .ce_o        (ce[i])
    );
  end

  assign ready       = (state_q == RUN);
  assign unlock_seen = unlock_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
module tb_clock_enable_gen;

  localparam int NUM_CH  = 3;
  localparam int ACC_W   = 32;
  localparam int LW      = 16;
  localparam int RUN_LEN = 24;

  logic             clk = 1'b0;
  logic             rst, pll_locked, cfg_we, sync_req;
  logic [2:0]       cfg_ch;
  logic [ACC_W-1:0] cfg_inc, cfg_phase;
  logic [NUM_CH-1:0] ce;
  logic             ready, unlock_seen;

  clock_enable_gen #(.NUM_CH(NUM_CH), .ACC_WIDTH(ACC_W), .LOCK_WAIT(LW)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .sync_req(sync_req),
    .ce(ce), .ready(ready), .unlock_seen(unlock_seen)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-channel config plus the closed-form expected pulse train:
  // first RUN cycle (R1 = first cycle with ready=1) carrying a pulse, and period.
  typedef struct packed {
    logic [2:0][31:0] inc;
    logic [2:0][31:0] phase;
    logic [2:0][7:0]  first;
    logic [2:0][7:0]  period;   // 0 = never pulses
  } vec_t;

  vec_t vecs[4];
  logic [3:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_ce(input vec_t v, input int k);
    logic [2:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      if (v.period[c] != 0 && k >= int'(v.first[c]) &&
          ((k - int'(v.first[c])) % int'(v.period[c])) == 0)
        r[c] = 1'b1;
    end
    return r;
  endfunction

  // Entry: at negedge of cycle R(k0-1) (or the ALIGN cycle when k0 = 1).
  task automatic check_run(input vec_t v, input string tag, input int k0);
    for (int k = k0; k <= RUN_LEN; k++) begin
      sb_q.push_back({1'b1, exp_ce(v, k)});
      @(posedge clk); @(negedge clk);
      check($sformatf("%s {ready,ce} R%0d", tag, k), 32'({ready, ce}), 32'(sb_q.pop_front()));
    end
  endtask

  // Writes ch0..ch2; the last write shares its cycle with sync_req, so the
  // ALIGN that follows must already use the new ch2 phase.
  task automatic apply_vec(input vec_t v, input string tag);
    for (int c = 0; c < 3; c++) begin
      cfg_we = 1'b1; cfg_ch = 3'(c); cfg_inc = v.inc[c]; cfg_phase = v.phase[c];
      sync_req = (c == 2);
      @(posedge clk); @(negedge clk);
    end
    cfg_we = 1'b0; sync_req = 1'b0;
    check({tag, " ALIGN {ready,ce}"}, 32'({ready, ce}), 32'h0);
  endtask

  // Waits (bounded) until ready is seen high at a negedge; ce must stay 0 meanwhile.
  task automatic wait_ready(input string tag, output int edges);
    logic stray;
    stray = 1'b0;
    edges = 0;
    while (!ready && edges < LW + 20) begin
      @(posedge clk); @(negedge clk);
      edges++;
      if (!ready && ce != '0) stray = 1'b1;
    end
    check({tag, " ready seen"}, 32'(ready), 32'h1);
    check({tag, " ce quiet before ready"}, 32'(stray), 32'h0);
  endtask

  initial begin
    int k, cnt;
    vecs[0] = '{inc:   '{32'h0, 32'h2000_0000, 32'h8000_0000},
                phase: '{32'h0, 32'h8000_0000, 32'h0},
                first: '{8'd0, 8'd5, 8'd3}, period: '{8'd0, 8'd8, 8'd2}};
    vecs[1] = '{inc:   '{32'h4000_0000, 32'h2000_0000, 32'h2000_0000},
                phase: '{32'hC000_0000, 32'h8000_0000, 32'h0},
                first: '{8'd2, 8'd5, 8'd9}, period: '{8'd4, 8'd8, 8'd8}};
    vecs[2] = '{inc:   '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                phase: '{32'h8000_0000, 32'h8000_0000, 32'h0},
                first: '{8'd2, 8'd2, 8'd3}, period: '{8'd2, 8'd1, 8'd1}};
    vecs[3] = '{inc:   '{32'h5555_5555, 32'h0, 32'h1000_0000},
                phase: '{32'h0, 32'hFFFF_FFFF, 32'hF000_0000},
                first: '{8'd5, 8'd0, 8'd2}, period: '{8'd3, 8'd0, 8'd16}};

    rst = 1'b1; pll_locked = 1'b1; cfg_we = 1'b0; sync_req = 1'b0;
    cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ce", 32'(ce), 32'h0);
    check("reset ready", 32'(ready), 32'h0);
    check("reset unlock_seen", 32'(unlock_seen), 32'h0);

    // Lock-up latency: edge 1 is the first edge sampling rst low.
    rst = 1'b0;
    k = 0;
    while (!ready && k < LW + 20) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    // ready became visible after edge k; edge k+1 is the first to sample it high.
    check("ready rise edge", 32'(k + 1), 32'(LW + 4));
    check("unlock_seen after clean lock", 32'(unlock_seen), 32'h0);

    for (int i = 0; i < 4; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
      check_run(vecs[i], $sformatf("vec%0d", i), 1);
    end

    // Write to a non-existent channel together with sync: phases unchanged.
    cfg_we = 1'b1; cfg_ch = 3'd7; cfg_inc = 32'h0; cfg_phase = 32'h4000_0000; sync_req = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_we = 1'b0; sync_req = 1'b0;
    check("ch7 ALIGN {ready,ce}", 32'({ready, ce}), 32'h0);
    check_run(vecs[3], "ch7 ignored", 1);

    // One-cycle lock drop: unlock reaches the FSM two edges later.
    pll_locked = 1'b0;
    @(posedge clk); @(negedge clk);
    pll_locked = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("unlock ready", 32'(ready), 32'h0);
    check("unlock ce", 32'(ce), 32'h0);
    check("unlock_seen set", 32'(unlock_seen), 32'h1);
    wait_ready("relock", k);
    check("relock R1 {ready,ce}", 32'({ready, ce}), 32'({1'b1, exp_ce(vecs[3], 1)}));
    check_run(vecs[3], "relock", 2);
    check("unlock_seen sticky", 32'(unlock_seen), 32'h1);

    // Default-style 1/9 ratio on ch0 over 9000 RUN cycles.
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_inc = 32'h1C71_C71C; cfg_phase = 32'h0; sync_req = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_we = 1'b0; sync_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 9000; i++) begin
      @(posedge clk); @(negedge clk);
      if (ce[0]) cnt++;
    end
    n_tests++;
    if (!(cnt == 999 || cnt == 1000)) begin
      n_fail++;
      $display("FAIL ratio 1/9 pulse count: got %0d expected 999 or 1000", cnt);
    end

    // Reset in the middle of RUN: everything drops on the next edge.
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrun rst ce", 32'(ce), 32'h0);
    check("midrun rst ready", 32'(ready), 32'h0);
    check("midrun rst unlock_seen", 32'(unlock_seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent clock-enable channels, range 1..8.
REQ-002 Parameter ACC_WIDTH, default 32: phase-accumulator width in bits, range 8..32.
REQ-003 Parameter LOCK_WAIT, default 1024: cycles pll_locked must stay high before enables start.
REQ-004 clk  in  1  system clock, the PLL fast output (nominal 117.9648 MHz); sole clock of the block.
REQ-005 rst  in  1  reset, synchronous to clk, active-high.
REQ-006 pll_locked  in  1  raw PLL lock flag, asynchronous to clk.
REQ-007 cfg_we  in  1  config write strobe, single cycle.
REQ-008 cfg_ch  in  3  channel index for the write.
REQ-009 cfg_inc  in  ACC_WIDTH  per-channel increment; f_ce = f_clk*inc/2^ACC_WIDTH.
REQ-010 cfg_phase  in  ACC_WIDTH  per-channel start-phase offset.
REQ-011 sync_req  in  1  request to realign all channels to their phase offsets.
REQ-012 ce  out  NUM_CH  one-cycle clock-enable pulses, one bit per channel.
REQ-013 ready  out  1  high while channels run (state RUN).
REQ-014 unlock_seen  out  1  sticky: lock lost since reset.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchroniser; all uses below refer to the synchronised value.
REQ-016 FSM states SHALL be WAIT_LOCK, ALIGN, RUN.
REQ-017 WAIT_LOCK: lock counter increments while locked=1 and clears when locked=0; on reaching LOCK_WAIT-1, go to ALIGN.
REQ-018 ALIGN SHALL last exactly one cycle: load every acc[i] with phase[i], then go to RUN.
REQ-019 RUN: each cycle, {carry, acc[i]} = acc[i] + inc[i] computed at ACC_WIDTH+1 bits; acc[i] takes the low ACC_WIDTH bits; ce[i] is registered carry, one cycle after the add.
REQ-020 In RUN, sync_req=1 SHALL go to ALIGN; ce is 0 during ALIGN.
REQ-021 In any state, locked=0 SHALL go to WAIT_LOCK, clear the lock counter, force ce=0 the next cycle, and set unlock_seen.
REQ-022 cfg_we with cfg_ch<NUM_CH SHALL update inc[cfg_ch] and phase[cfg_ch] at the clock edge; cfg_ch>=NUM_CH is ignored.
REQ-023 A new inc SHALL apply from the next add without disturbing acc; a new phase applies only at the next ALIGN.
REQ-024 cfg_we and sync_req in the same cycle: the ALIGN that follows SHALL use the newly written phase.
REQ-025 Boundaries: inc=0 gives ce never; inc=2^ACC_WIDTH-1 gives ce on all but one cycle in 2^ACC_WIDTH; wrap-around is modulo 2^ACC_WIDTH with no saturation.
REQ-026 ready SHALL be 1 exactly in RUN.

Reset
REQ-027 rst SHALL force state WAIT_LOCK, lock counter 0, all acc 0, ce 0, ready 0, and unlock_seen 0; the synchroniser flops also clear to 0.
REQ-028 Reset values: inc[i] = 2^ACC_WIDTH/9 (truncated), phase[i] = 0.
REQ-029 rst asserted mid-RUN SHALL drop ce and ready on the next edge, with no partial pulse.

Structure
REQ-030 Shared package clock_gen_pkg SHALL hold the FSM state enum, the default-increment constant, and the NUM_CH maximum.
REQ-031 One sub-module, clock_enable_nco, SHALL implement a single channel (acc, add, carry register, load) and be instantiated NUM_CH times.

Verification
REQ-032 Hold locked=1 from reset: ready rises LOCK_WAIT+4 cycles after rst deasserts (2 synchroniser + count + ALIGN), ±0, checked exactly.
REQ-033 ACC_WIDTH=32, inc=0x80000000, phase=0: ce toggles 0,1,0,1; inc=0x1C71C71C: 9,000,000 RUN cycles yield 999,999 or 1,000,000 pulses.
REQ-034 ch0 phase=0, ch1 phase=0x80000000, both inc=0x20000000, then sync_req: ch1 pulses lead ch0 by exactly 4 cycles, period 8.
REQ-035 Drop locked for 1 cycle mid-RUN: ce goes 0, ready falls, unlock_seen=1 and stays set; after re-lock, ce restarts aligned.
REQ-036 cfg_we with cfg_ch=7, NUM_CH=3: no register changes; cfg_we and sync_req together: the post-ALIGN first pulse timing matches the new phase.
